// File: rtl/softmax_grad_layer.sv
// rtl/softmax_grad_layer.sv - per-token softmax cross-entropy gradient with argmax prediction
// Sequential max / base-2 exp / reciprocal / normalise passes, one element per cycle.
module softmax_grad_layer #(
    parameter int N        = 10,
    parameter int CHAR_NUM = 200,
    parameter int N_LEN    = 16,
    parameter int F_LEN    = 8,
    parameter int N_LEN_W  = 16,
    parameter int F_LEN_W  = 14,
    parameter int IDX_W    = $clog2(CHAR_NUM)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic [N*CHAR_NUM*N_LEN-1:0]     d_forward,
    input  logic [N*IDX_W-1:0]              d_label,
    output logic                            valid,
    output logic [N*CHAR_NUM*N_LEN_W-1:0]   q_backward,
    output logic [N*IDX_W-1:0]              q_pred
);

    localparam int I_W   = (IDX_W > 5) ? IDX_W : 5;
    localparam int T_W   = (N > 1) ? $clog2(N) : 1;
    localparam int S_W   = 16 + IDX_W;
    localparam int P_W   = N_LEN + 11;
    localparam int DF_AW = $clog2(N*CHAR_NUM*N_LEN);
    localparam int QB_AW = $clog2(N*CHAR_NUM*N_LEN_W);
    localparam int LB_AW = $clog2(N*IDX_W);
    localparam logic [I_W-1:0] I_LAST     = I_W'(CHAR_NUM - 1);
    localparam logic [I_W-1:0] RECIP_LAST = I_W'(31);
    localparam logic [T_W-1:0] T_LAST     = T_W'(N - 1);

    typedef enum logic [2:0] {IDLE, MAX, EXP, RECIP, NORM, DONE} state_t;
    state_t state, state_nxt;

    logic [T_W-1:0]          t;
    logic [I_W-1:0]          i;
    logic signed [N_LEN-1:0] m;
    logic [IDX_W-1:0]        m_idx;
    logic [S_W-1:0]          sum;
    logic [S_W-1:0]          rem;
    logic [31:0]             dvd;
    logic [15:0]             r;
    logic [15:0]             e_buf [CHAR_NUM];

    logic [31:0]             elem;
    logic signed [N_LEN-1:0] x;
    logic [IDX_W-1:0]        label;
    logic                    take_max;
    logic [IDX_W-1:0]        max_idx;
    logic signed [N_LEN:0]   y;
    logic signed [P_W-1:0]   z;
    logic signed [P_W-1:0]   k;
    logic signed [P_W-1:0]   nk;
    logic [15:0]             mant;
    logic [15:0]             e;
    logic [S_W:0]            rs;
    logic                    rs_ge;
    logic [15:0]             p;
    logic signed [16:0]      g;
    logic [N_LEN_W-1:0]      gq;

    always_comb begin
        elem     = 32'(t) * CHAR_NUM + 32'(i);
        x        = d_forward[DF_AW'(elem * N_LEN) +: N_LEN];
        label    = d_label[LB_AW'(32'(t) * IDX_W) +: IDX_W];
        take_max = (i == '0) || (x > m);
        max_idx  = take_max ? IDX_W'(i) : m_idx;
        // 2^(y*log2(e)): integer part becomes a right shift, fraction feeds a linear mantissa
        y        = {x[N_LEN-1], x} - {m[N_LEN-1], m};
        z        = (P_W'(y) * P_W'(369)) >>> 8;
        k        = z >>> F_LEN;
        nk       = -k;
        mant     = 16'h8000 | (16'(z[F_LEN-1:0]) << (15 - F_LEN));
        e        = (|nk[P_W-1:4]) ? 16'd0 : (mant >> nk[3:0]);
        rs       = {rem, dvd[31]};
        rs_ge    = (rs >= {1'b0, sum});
        p        = 16'((32'(e_buf[i]) * 32'(r)) >> 15);
        g        = $signed({1'b0, p}) - ((i == I_W'(label)) ? 17'sh08000 : 17'sh00000);
        gq       = N_LEN_W'(g >>> (15 - F_LEN_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = MAX;
            MAX:     if (!run) state_nxt = IDLE; else if (i == I_LAST) state_nxt = EXP;
            EXP:     if (!run) state_nxt = IDLE; else if (i == I_LAST) state_nxt = RECIP;
            RECIP:   if (!run) state_nxt = IDLE; else if (i == RECIP_LAST) state_nxt = NORM;
            NORM: begin
                if (!run)             state_nxt = IDLE;
                else if (i == I_LAST) state_nxt = (t == T_LAST) ? DONE : MAX;
            end
            DONE:    if (!run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t          <= '0;
            i          <= '0;
            m          <= '0;
            m_idx      <= '0;
            sum        <= '0;
            rem        <= '0;
            dvd        <= '0;
            r          <= '0;
            valid      <= 1'b0;
            q_backward <= '0;
            q_pred     <= '0;
        end else begin
            valid <= (state == DONE) && run;
            case (state)
                IDLE: begin
                    t <= '0;
                    i <= '0;
                end
                MAX: if (run) begin
                    if (take_max) begin
                        m     <= x;
                        m_idx <= IDX_W'(i);
                    end
                    if (i == I_LAST) begin
                        q_pred[LB_AW'(32'(t) * IDX_W) +: IDX_W] <= max_idx;
                        i   <= '0;
                        sum <= '0;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                EXP: if (run) begin
                    sum <= sum + S_W'(e);
                    if (i == I_LAST) begin
                        i   <= '0;
                        rem <= '0;
                        dvd <= 32'h4000_0000;
                        r   <= '0;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                // restoring division of 2^30 by sum, one quotient bit per cycle
                RECIP: if (run) begin
                    rem <= rs_ge ? S_W'(rs - {1'b0, sum}) : S_W'(rs);
                    r   <= {r[14:0], rs_ge};
                    dvd <= {dvd[30:0], 1'b0};
                    i   <= (i == RECIP_LAST) ? '0 : i + 1'b1;
                end
                NORM: if (run) begin
                    q_backward[QB_AW'(elem * N_LEN_W) +: N_LEN_W] <= gq;
                    if (i == I_LAST) begin
                        i <= '0;
                        if (t != T_LAST) t <= t + 1'b1;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == EXP && run) e_buf[i] <= e;
    end

endmodule

// File: tb/tb_softmax_grad_layer.sv
// tb/tb_softmax_grad_layer.sv - directed self-checking bench for softmax_grad_layer
// Scenarios: uniform, dominant, tie, out-of-range label, abort, async reset.
module tb_softmax_grad_layer;

    localparam int N   = 10;
    localparam int CN  = 200;
    localparam int NL  = 16;
    localparam int NLW = 16;
    localparam int IW  = 8;
    localparam int LAT = 6321;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  run = 1'b0;
    logic [N*CN*NL-1:0]    d_forward;
    logic [N*IW-1:0]       d_label;
    logic                  valid;
    logic [N*CN*NLW-1:0]   q_backward;
    logic [N*IW-1:0]       q_pred;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    softmax_grad_layer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .d_forward  (d_forward),
        .d_label    (d_label),
        .valid      (valid),
        .q_backward (q_backward),
        .q_pred     (q_pred)
    );

    function automatic logic [15:0] exp_g(input int sc, input int i);
        case (sc)
            0:       return (i == 5) ? 16'hC051 : 16'h0051;
            2:       return (i == 3) ? 16'hE000 : ((i == 9) ? 16'h2000 : 16'h0000);
            3:       return 16'h0051;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] exp_p(input int sc);
        case (sc)
            1:       return 8'd7;
            2:       return 8'd3;
            default: return 8'd0;
        endcase
    endfunction

    // scenario 0: all 0, label 5; 1: label logit +100.0; 2: tie at 3/9; 3: label 255
    task automatic load(input int sc);
        logic [15:0] v;
        logic [7:0]  lbl;
        for (int t = 0; t < N; t++) begin
            for (int i = 0; i < CN; i++) begin
                v = 16'h0000;
                if (sc == 1 && i == 7) v = 16'h6400;
                if (sc == 2) v = (i == 3 || i == 9) ? 16'h0100 : 16'h9C00;
                d_forward[(t*CN+i)*NL +: NL] = v;
            end
            lbl = (sc == 0) ? 8'd5 : (sc == 1) ? 8'd7 : (sc == 2) ? 8'd3 : 8'd255;
            d_label[t*IW +: IW] = lbl;
        end
    endtask

    task automatic scan(input int sc, input int t_lo, input int t_hi,
                        output int bad_g, output string msg_g,
                        output int bad_p, output string msg_p);
        logic [15:0] got;
        bad_g = 0; bad_p = 0; msg_g = ""; msg_p = "";
        for (int t = t_lo; t <= t_hi; t++) begin
            for (int i = 0; i < CN; i++) begin
                got = q_backward[(t*CN+i)*NLW +: NLW];
                if (got !== exp_g(sc, i)) begin
                    if (bad_g == 0)
                        msg_g = $sformatf("t=%0d i=%0d got %h required %h", t, i, got, exp_g(sc, i));
                    bad_g++;
                end
            end
            if (q_pred[t*IW +: IW] !== exp_p(sc)) begin
                if (bad_p == 0)
                    msg_p = $sformatf("t=%0d got %0d required %0d", t, q_pred[t*IW +: IW], exp_p(sc));
                bad_p++;
            end
        end
    endtask

    task automatic run_to_valid(output int lat);
        @(negedge clk);
        run = 1'b1;
        lat = -1;
        for (int j = 0; j < 7000; j++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic drop_run;
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", valid); else n_pass++;
        n_checks++; if (q_pred !== '0) $display("FAIL reset_pred: got %h required 0", q_pred); else n_pass++;
        n_checks++; if (q_backward !== '0) $display("FAIL reset_qb: got nonzero=%b required 0", |q_backward); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_uniform;
        int lat, bg, bp;
        string mg, mp;
        load(0);
        run_to_valid(lat);
        n_checks++; if (lat !== LAT) $display("FAIL uniform_latency: got %0d required %0d", lat, LAT); else n_pass++;
        scan(0, 0, N-1, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL uniform_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL uniform_pred: %0d wrong, %s", bp, mp); else n_pass++;
        drop_run();
        n_checks++; if (valid !== 1'b0) $display("FAIL uniform_valid_fall: got %b required 0", valid); else n_pass++;
    endtask

    task automatic test_dominant;
        int lat, bg, bp;
        string mg, mp;
        load(1);
        run_to_valid(lat);
        scan(1, 0, N-1, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL dominant_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL dominant_pred: %0d wrong, %s", bp, mp); else n_pass++;
        drop_run();
    endtask

    task automatic test_tie;
        int lat, bg, bp;
        string mg, mp;
        load(2);
        run_to_valid(lat);
        scan(2, 0, N-1, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL tie_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL tie_pred: %0d wrong, %s", bp, mp); else n_pass++;
        drop_run();
    endtask

    task automatic test_label_oob;
        int lat, bg, bp;
        string mg, mp;
        load(3);
        run_to_valid(lat);
        scan(3, 0, N-1, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL oob_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL oob_pred: %0d wrong, %s", bp, mp); else n_pass++;
        drop_run();
    endtask

    task automatic test_abort;
        int lat, bg, bp, vhigh;
        string mg, mp;
        load(1);
        vhigh = 0;
        @(negedge clk);
        run = 1'b1;
        for (int j = 0; j < 2600; j++) begin
            @(posedge clk);
            #1;
            if (valid) vhigh++;
        end
        drop_run();
        repeat (3) begin
            @(posedge clk);
            #1;
            if (valid) vhigh++;
        end
        n_checks++; if (vhigh !== 0) $display("FAIL abort_valid: high %0d cycles required 0", vhigh); else n_pass++;
        scan(1, 0, 3, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL abort_new_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL abort_new_pred: %0d wrong, %s", bp, mp); else n_pass++;
        scan(3, 4, N-1, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL abort_old_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL abort_old_pred: %0d wrong, %s", bp, mp); else n_pass++;
        run_to_valid(lat);
        n_checks++; if (lat !== LAT) $display("FAIL rerun_latency: got %0d required %0d", lat, LAT); else n_pass++;
        scan(1, 0, N-1, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL rerun_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL rerun_pred: %0d wrong, %s", bp, mp); else n_pass++;
        drop_run();
    endtask

    task automatic test_reset_mid;
        int lat, bg, bp;
        string mg, mp;
        load(2);
        @(negedge clk);
        run = 1'b1;
        for (int j = 0; j < 416; j++) @(posedge clk);
        #1;
        n_checks++; if (q_pred[0 +: IW] !== 8'd3) $display("FAIL recip_pre_pred: got %0d required 3", q_pred[0 +: IW]); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL recip_rst_valid: got %b required 0", valid); else n_pass++;
        n_checks++; if (q_pred !== '0) $display("FAIL recip_rst_pred: got %h required 0", q_pred); else n_pass++;
        n_checks++; if (q_backward !== '0) $display("FAIL recip_rst_qb: got nonzero=%b required 0", |q_backward); else n_pass++;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        load(0);
        run_to_valid(lat);
        n_checks++; if (lat !== LAT) $display("FAIL post_rst_latency: got %0d required %0d", lat, LAT); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL done_rst_valid: got %b required 0", valid); else n_pass++;
        n_checks++; if (q_pred !== '0) $display("FAIL done_rst_pred: got %h required 0", q_pred); else n_pass++;
        n_checks++; if (q_backward !== '0) $display("FAIL done_rst_qb: got nonzero=%b required 0", |q_backward); else n_pass++;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_to_valid(lat);
        n_checks++; if (lat !== LAT) $display("FAIL final_latency: got %0d required %0d", lat, LAT); else n_pass++;
        scan(0, 0, N-1, bg, mg, bp, mp);
        n_checks++; if (bg !== 0) $display("FAIL final_grad: %0d wrong, %s", bg, mg); else n_pass++;
        n_checks++; if (bp !== 0) $display("FAIL final_pred: %0d wrong, %s", bp, mp); else n_pass++;
        drop_run();
    endtask

    initial begin
        d_forward = '0;
        d_label   = '0;
        test_reset();
        test_uniform();
        test_dominant();
        test_tie();
        test_label_oob();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
